// File: rtl/prog_seq_detector.sv
`timescale 1ns/1ps
// Run-time programmable serial pattern detector with a saturating match counter.
// Latency: o is combinational (same cycle as the last pattern bit); state updates on the next edge.
// Backpressure: none; the source qualifies bits with i_valid and the detector holds while it is low.
module prog_seq_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               i_valid,
    input  logic               i,
    input  logic               clr_cnt,
    output logic               o,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(4'b1101);
    localparam logic [LEN_W-1:0]   DEFAULT_LEN = LEN_W'(4);
    localparam logic [LEN_W-1:0]   FULL_LEN    = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    // The oldest accepted bit can never take part in a compare, so only
    // MAX_LEN-1 bits of history are kept; the current bit completes the window.
    logic [MAX_LEN-2:0] history;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic               armed;
    logic               hit;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   fill_next;

    always_comb begin
        window = {history, i};
        mask   = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            mask[k] = (LEN_W'(k) < cfg_len);
        end
        // fill guard stops a pattern of zeros matching the cleared history
        armed = (cfg_len >= LEN_W'(2)) && (fill >= (cfg_len - LEN_W'(1)));
        hit   = (((window ^ cfg_pat) & mask) == '0);
        o     = i_valid & ~load & ~rst & armed & hit;
    end

    always_comb begin
        len_clamped = (pat_len > FULL_LEN) ? FULL_LEN : pat_len;
        fill_next   = (fill >= FULL_LEN) ? FULL_LEN : fill + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_pat     <= DEFAULT_PAT;
            cfg_len     <= DEFAULT_LEN;
            history     <= '0;
            fill        <= '0;
            match_count <= '0;
        end else begin
            if (load) begin
                cfg_pat <= pat;
                cfg_len <= len_clamped;
                history <= '0;
                fill    <= '0;
            end else if (i_valid) begin
                if (o && !overlap) begin
                    history <= '0;
                    fill    <= '0;
                end else begin
                    history <= window[MAX_LEN-2:0];
                    fill    <= fill_next;
                end
            end

            if (clr_cnt) begin
                match_count <= '0;
            end else if (o && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule
